// File: rtl/egress_frame_arbiter_pkg.sv
// Shared types for the egress frame arbiter: stream structs, FSM states,
// the abort terminator word and a saturating counter helper.
package egress_frame_arbiter_pkg;

  // Stream structs match the layout used by packet_filter.svh.
  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ABORT  = 2'd2
  } arb_state_e;

  localparam logic [15:0] ABORT_DATA = 16'h0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/egress_frame_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// after ptr, wrapping around NUM_PORTS.
module egress_frame_arbiter_rr_pick
  import egress_frame_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [$clog2(NUM_PORTS)-1:0] idx,
  output logic                         any
);

  localparam int W = $clog2(NUM_PORTS);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      int c;
      c   = (int'(ptr) + i) % NUM_PORTS;
      any = any | req[c];
      idx = req[c] ? W'(c) : idx;
    end
  end

endmodule

// File: rtl/egress_frame_arbiter.sv
// Frame-granular round-robin arbiter merging per-port frame FIFOs onto one
// egress stream, with a stall watchdog that terminates starved frames.
module egress_frame_arbiter
  import egress_frame_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  axis_source_t                 port_src [NUM_PORTS],
  output axis_sink_t                   port_sink [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]         frame_avail,
  output axis_source_t                 egress_source,
  input  axis_sink_t                   egress_sink,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         frame_abort,
  output logic [15:0]                  abort_count
);

  localparam int W  = $clog2(NUM_PORTS);
  localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = (STALL_LIMIT > 0) ? SW'(STALL_LIMIT - 1) : '0;

  arb_state_e   state, next_state;
  logic [W-1:0] rr_ptr, next_ptr, next_grant, ptr_after, pick_idx;
  logic [SW-1:0] stall_cnt, next_stall;
  logic [15:0]  next_count;
  logic         next_abort, pick_any;
  axis_source_t granted;

  egress_frame_arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req (frame_avail),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign granted   = port_src[grant_id];
  assign ptr_after = (grant_id == W'(NUM_PORTS - 1)) ? '0 : grant_id + W'(1);

  // Next-state, grant, watchdog and abort bookkeeping.
  always_comb begin
    next_state = state;
    next_grant = grant_id;
    next_ptr   = rr_ptr;
    next_stall = stall_cnt;
    next_count = abort_count;
    next_abort = 1'b0;
    case (state)
      IDLE: begin
        next_stall = '0;
        if (pick_any) begin
          next_state = STREAM;
          next_grant = pick_idx;
        end else begin
          next_state = IDLE;
        end
      end
      STREAM: begin
        next_stall = granted.tvalid ? '0 : stall_cnt + SW'(1);
        if (granted.tvalid && egress_sink.tready && granted.tlast) begin
          next_state = IDLE;
          next_ptr   = ptr_after;
        end else if ((STALL_LIMIT != 0) && !granted.tvalid && (stall_cnt == STALL_LAST)) begin
          // This idle cycle is the STALL_LIMIT-th in a row.
          next_state = ABORT;
        end else begin
          next_state = STREAM;
        end
      end
      ABORT: begin
        next_stall = '0;
        if (egress_sink.tready) begin
          next_state = IDLE;
          next_ptr   = ptr_after;
          next_abort = 1'b1;
          next_count = sat_inc16(abort_count);
        end else begin
          next_state = ABORT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: passthrough while streaming, terminator beat while aborting.
  always_comb begin
    egress_source = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_sink[p] = '0;
    end
    case (state)
      IDLE: begin
        egress_source = '0;
      end
      STREAM: begin
        egress_source                = granted;
        port_sink[grant_id].tready   = egress_sink.tready;
      end
      ABORT: begin
        egress_source = '{tvalid: 1'b1, tdata: ABORT_DATA, tlast: 1'b1};
      end
      default: begin
        egress_source = '0;
      end
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      stall_cnt   <= '0;
      abort_count <= 16'h0000;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      rr_ptr      <= next_ptr;
      grant_id    <= next_grant;
      stall_cnt   <= next_stall;
      abort_count <= next_count;
      frame_abort <= next_abort;
      busy        <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_egress_frame_arbiter.sv
// Directed self-checking bench for egress_frame_arbiter (4 ports, stall limit 4).
module tb_egress_frame_arbiter;
  import egress_frame_arbiter_pkg::*;

  logic         clk;
  logic         reset;
  axis_source_t port_src [4];
  axis_sink_t   port_sink [4];
  logic [3:0]   frame_avail;
  axis_source_t egress_source;
  axis_sink_t   egress_sink;
  logic [1:0]   grant_id;
  logic         busy;
  logic         frame_abort;
  logic [15:0]  abort_count;
  logic [3:0]   rdy;

  int vectors;
  int miscompares;

  egress_frame_arbiter #(.NUM_PORTS(4), .STALL_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_src      (port_src),
    .port_sink     (port_sink),
    .frame_avail   (frame_avail),
    .egress_source (egress_source),
    .egress_sink   (egress_sink),
    .grant_id      (grant_id),
    .busy          (busy),
    .frame_abort   (frame_abort),
    .abort_count   (abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rdy = 4'b0000;
    for (int p = 0; p < 4; p++) rdy[p] = port_sink[p].tready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int p, input logic v, input logic [15:0] d, input logic l);
    port_src[p] = '{tvalid: v, tdata: d, tlast: l};
  endtask

  task automatic clear_src();
    for (int p = 0; p < 4; p++) port_src[p] = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    frame_avail = 4'b0000;
    egress_sink = '0;
    clear_src();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_tvalid", {31'd0, egress_source.tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, egress_source.tdata}, 32'd0);
    chk("rst_tlast", {31'd0, egress_source.tlast}, 32'd0);
    chk("rst_rdy", {28'd0, rdy}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    chk("rst_count", {16'd0, abort_count}, 32'd0);
    tick();

    // Fairness: every port always requesting, 3-beat frames.
    egress_sink.tready = 1'b1;
    frame_avail = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      int ep;
      ep = f % 4;
      for (int p = 0; p < 4; p++) set_src(p, 1'b1, 16'(16'h0100 * p), 1'b0);
      #1;
      chk("fair_bubble_busy", {31'd0, busy}, 32'd0);
      chk("fair_bubble_tvalid", {31'd0, egress_source.tvalid}, 32'd0);
      tick();
      for (int b = 0; b < 3; b++) begin
        for (int p = 0; p < 4; p++) set_src(p, 1'b1, 16'(16'h0100 * p + b), (b == 2));
        #1;
        chk("fair_grant", {30'd0, grant_id}, 32'(ep));
        chk("fair_busy", {31'd0, busy}, 32'd1);
        chk("fair_tdata", {16'd0, egress_source.tdata}, 32'(16'h0100 * ep + b));
        chk("fair_tlast", {31'd0, egress_source.tlast}, (b == 2) ? 32'd1 : 32'd0);
        chk("fair_rdy", {28'd0, rdy}, 32'(4'b0001 << ep));
        tick();
      end
    end

    // Single requester on port 2, 4-beat frame.
    frame_avail = 4'b0100;
    clear_src();
    set_src(2, 1'b1, 16'h2A00, 1'b0);
    #1;
    chk("sp_idle_busy", {31'd0, busy}, 32'd0);
    chk("sp_idle_rdy", {28'd0, rdy}, 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_src(2, 1'b1, 16'(16'h2A00 + b), (b == 3));
      frame_avail = 4'b0000;
      #1;
      chk("sp_grant", {30'd0, grant_id}, 32'd2);
      chk("sp_tdata", {16'd0, egress_source.tdata}, 32'(16'h2A00 + b));
      chk("sp_tlast", {31'd0, egress_source.tlast}, (b == 3) ? 32'd1 : 32'd0);
      chk("sp_rdy", {28'd0, rdy}, 32'h4);
      tick();
    end
    clear_src();
    #1;
    chk("sp_end_busy", {31'd0, busy}, 32'd0);
    chk("sp_end_tvalid", {31'd0, egress_source.tvalid}, 32'd0);

    // Backpressure on port 3, which must win next because rr_ptr is 3.
    frame_avail = 4'b1111;
    set_src(3, 1'b1, 16'h3B00, 1'b0);
    tick();
    #1;
    chk("bp_grant", {30'd0, grant_id}, 32'd3);
    chk("bp_rdy1", {28'd0, rdy}, 32'h8);
    frame_avail = 4'b0000;
    tick();
    set_src(3, 1'b1, 16'h3B01, 1'b0);
    egress_sink.tready = 1'b0;
    #1;
    chk("bp_rdy0a", {28'd0, rdy}, 32'h0);
    chk("bp_hold_tdata", {16'd0, egress_source.tdata}, 32'h3B01);
    tick();
    egress_sink.tready = 1'b1;
    #1;
    chk("bp_rdy1b", {28'd0, rdy}, 32'h8);
    chk("bp_tdata1", {16'd0, egress_source.tdata}, 32'h3B01);
    tick();
    set_src(3, 1'b1, 16'h3B02, 1'b1);
    egress_sink.tready = 1'b0;
    #1;
    chk("bp_rdy0b", {28'd0, rdy}, 32'h0);
    chk("bp_tlast_held", {31'd0, egress_source.tlast}, 32'd1);
    tick();
    egress_sink.tready = 1'b1;
    #1;
    chk("bp_rdy1c", {28'd0, rdy}, 32'h8);
    chk("bp_tdata2", {16'd0, egress_source.tdata}, 32'h3B02);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    tick();
    clear_src();
    #1;
    chk("bp_end_busy", {31'd0, busy}, 32'd0);
    chk("bp_end_tvalid", {31'd0, egress_source.tvalid}, 32'd0);

    // Watchdog: port 1 sends 2 beats, then stalls 4 cycles.
    frame_avail = 4'b0010;
    set_src(1, 1'b1, 16'h1C00, 1'b0);
    tick();
    #1;
    chk("wd_grant", {30'd0, grant_id}, 32'd1);
    chk("wd_tdata0", {16'd0, egress_source.tdata}, 32'h1C00);
    frame_avail = 4'b0000;
    tick();
    set_src(1, 1'b1, 16'h1C01, 1'b0);
    #1;
    chk("wd_tdata1", {16'd0, egress_source.tdata}, 32'h1C01);
    tick();
    for (int s = 0; s < 4; s++) begin
      set_src(1, 1'b0, 16'h0000, 1'b0);
      #1;
      chk("wd_stall_tvalid", {31'd0, egress_source.tvalid}, 32'd0);
      chk("wd_stall_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    egress_sink.tready = 1'b0;
    #1;
    chk("wd_term_tvalid", {31'd0, egress_source.tvalid}, 32'd1);
    chk("wd_term_tdata", {16'd0, egress_source.tdata}, 32'h0000);
    chk("wd_term_tlast", {31'd0, egress_source.tlast}, 32'd1);
    chk("wd_term_rdy", {28'd0, rdy}, 32'h0);
    chk("wd_term_noabort", {31'd0, frame_abort}, 32'd0);
    tick();
    egress_sink.tready = 1'b1;
    #1;
    chk("wd_term_held", {31'd0, egress_source.tvalid & egress_source.tlast}, 32'd1);
    chk("wd_term_count0", {16'd0, abort_count}, 32'd0);
    tick();
    #1;
    chk("wd_pulse", {31'd0, frame_abort}, 32'd1);
    chk("wd_pulse_grant", {30'd0, grant_id}, 32'd1);
    chk("wd_count", {16'd0, abort_count}, 32'd1);
    chk("wd_idle_busy", {31'd0, busy}, 32'd0);
    chk("wd_idle_tvalid", {31'd0, egress_source.tvalid}, 32'd0);
    tick();
    #1;
    chk("wd_pulse_once", {31'd0, frame_abort}, 32'd0);

    // Stall-limit boundary: 3 stalls, beat, 3 stalls, last beat on port 2.
    frame_avail = 4'b0100;
    set_src(2, 1'b1, 16'h2D00, 1'b0);
    tick();
    #1;
    chk("bd_grant", {30'd0, grant_id}, 32'd2);
    frame_avail = 4'b0000;
    tick();
    for (int s = 0; s < 3; s++) begin
      set_src(2, 1'b0, 16'h0000, 1'b0);
      #1;
      chk("bd_stall1", {31'd0, egress_source.tvalid}, 32'd0);
      tick();
    end
    set_src(2, 1'b1, 16'h2D01, 1'b0);
    #1;
    chk("bd_beat_tdata", {16'd0, egress_source.tdata}, 32'h2D01);
    chk("bd_beat_tlast", {31'd0, egress_source.tlast}, 32'd0);
    tick();
    for (int s = 0; s < 3; s++) begin
      set_src(2, 1'b0, 16'h0000, 1'b0);
      #1;
      chk("bd_stall2", {31'd0, egress_source.tvalid}, 32'd0);
      tick();
    end
    set_src(2, 1'b1, 16'h2D02, 1'b1);
    #1;
    chk("bd_last_tdata", {16'd0, egress_source.tdata}, 32'h2D02);
    chk("bd_last_tlast", {31'd0, egress_source.tlast}, 32'd1);
    tick();
    clear_src();
    #1;
    chk("bd_end_busy", {31'd0, busy}, 32'd0);
    chk("bd_no_abort", {31'd0, frame_abort}, 32'd0);
    chk("bd_count", {16'd0, abort_count}, 32'd1);

    // Reset asserted on the second beat of a port-3 frame.
    frame_avail = 4'b1000;
    set_src(3, 1'b1, 16'h3E00, 1'b0);
    tick();
    #1;
    chk("rm_grant", {30'd0, grant_id}, 32'd3);
    tick();
    set_src(3, 1'b1, 16'h3E01, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_tvalid", {31'd0, egress_source.tvalid}, 32'd0);
    chk("rm_tlast", {31'd0, egress_source.tlast}, 32'd0);
    chk("rm_rdy", {28'd0, rdy}, 32'h0);
    chk("rm_count", {16'd0, abort_count}, 32'd0);
    chk("rm_grant0", {30'd0, grant_id}, 32'd0);
    chk("rm_no_abort", {31'd0, frame_abort}, 32'd0);
    tick();
    #1;
    chk("rm_regrant", {30'd0, grant_id}, 32'd3);
    chk("rm_regrant_busy", {31'd0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
